fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
// - Parametrised instruction-fetch stage for the RISC-V core.
// - Sequentially fetches from a synchronous instruction ROM (1-cycle read latency).
// - Buffers fetched words in a QDEPTH-entry prefetch queue.
// - Hands {instr, pc, npc} to decode over a valid/ready handshake; backpressure replaces a global stop.
// - A redirect (branch/jump) flushes the queue and kills in-flight reads.
// PARAMETERS
// XLEN      32   PC width in bits
// RESET_PC  0    first fetch address after reset (word aligned)
// QDEPTH    4    prefetch queue entries; power of two, >=2
// IMEM_AW   11   instruction ROM word-address width
// PORTS
// clk             in   1        clock
// rst             in   1        synchronous, active-high reset
// redirect_valid  in   1        load redirect_pc as the new fetch PC this edge
// redirect_pc     in   XLEN     redirect target; bits[1:0] ignored (forced 0)
// imem_rden       out  1        ROM read enable
// imem_addr       out  IMEM_AW  ROM word address = fetch_pc[IMEM_AW+1:2]
// imem_rdata      in   32       ROM data, valid the cycle after a read
// out_valid       out  1        queue head valid
// out_ready       in   1        decode accepts head
// out_instr       out  32       head instruction
// out_pc          out  XLEN     head PC
// out_npc         out  XLEN     head PC + 4 (mod 2^XLEN)
// BEHAVIOUR
// - Reset values: fetch_pc=RESET_PC, queue empty, req_valid=0, state=S_RESET.
//   Outputs at reset: out_valid=0, imem_rden=0.
// - FSM: S_RESET -> S_RUN on the first edge with rst=0; S_RUN holds until rst.
//   rst in any state returns to S_RESET and empties the queue; rst beats redirect.
// - Issue, S_RUN only: imem_rden = (count + req_valid) < QDEPTH.
//   On an issue edge: req_valid<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps modulo 2^XLEN).
// - Push: on an edge with req_valid=1 and no redirect, {imem_rdata, req_pc} enters the queue tail.
// - Pop: on an edge with out_valid & out_ready. Push and pop on the same edge are both honoured.
//   Count limit guarantees no overflow; pop on empty cannot occur.
// - Redirect edge (rst=0), in any state:
//   - queue emptied, req_valid<=0 (in-flight response dropped), fetch_pc<={redirect_pc[XLEN-1:2],2'b00};
//   - a pop on that same edge is still a legal handshake: decode has consumed the word.
// - Latency: first S_RUN cycle issues, out_valid rises after the 2nd edge; redirect -> out_valid 2 edges later.
// - Throughput: 1 instr/cycle with out_ready held high.
// - Outputs are combinational from the queue head; out_instr/out_pc are don't-care while out_valid=0.
// STRUCTURE
// - fetch_pkg holds:
//   - typedef enum logic {S_RESET, S_RUN} fetch_state_t;
//   - typedef struct packed {logic [31:0] instr; logic [XLEN-1:0] pc;} fetch_entry_t;
//   - localparam INSTR_W=32.
// - Sub-module fetch_fifo: synchronous FIFO (depth, width params) with flush input, count, full/empty.
// - Top: FSM, PC register, request pipeline register, issue logic.
// TESTING
// 1. Release rst, out_ready=1, ROM[i]=0x1000+i -> out_pc 0,4,8,12 on consecutive cycles;
//    out_instr 0x1000..0x1003; out_npc=out_pc+4.
// 2. out_ready=0 for 10 cycles -> 4 entries queued, imem_rden=0 once full;
//    release -> pcs 0,4,8,... with no gap, loss or duplicate.
// 3. Queue holds 3 entries, redirect_pc=0x100 -> next out_valid 2 edges later with out_pc=0x100;
//    stale entries never appear.
// 4. Redirect on the edge a response returns -> that response is never pushed.
//    redirect_pc=0x103 -> out_pc=0x100.
// 5. rst pulsed mid-run with a full queue -> out_valid=0 next cycle; fetch restarts at RESET_PC.
//    rst+redirect together -> RESET_PC.
// 6. RESET_PC=0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000; out_npc of first entry = 0.

Source files
------------

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, queue entry layout, widths.
// No logic; imported by the interface, the queue and the top.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int INSTR_W    = 32;

    typedef enum logic {
        S_RESET,
        S_RUN
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0]    instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Bus bundle between fetch and its neighbours: redirect in, ROM port, decode handshake out.
// master = fetch stage, slave = ROM/decode/branch side.
interface fetch_prefetch_queue_if
    import fetch_pkg::*;
#(
    parameter int XLEN    = FETCH_XLEN,
    parameter int IMEM_AW = 11
);

    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                imem_rden;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [XLEN-1:0]     out_pc;
    logic [XLEN-1:0]     out_npc;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_rden, imem_addr, out_valid, out_instr, out_pc, out_npc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_rden, imem_addr, out_valid, out_instr, out_pc, out_npc
    );

endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// Synchronous FIFO with flush; head is combinational from storage (0-cycle read).
// Caller guarantees no push when full and no pop when empty; flush beats push/pop.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed behind a nonzero count.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch: sequential ROM reads into a prefetch queue, {instr,pc,npc} out on valid/ready.
// First word 2 edges after first issue; redirect refills 2 edges later; decode stalls via out_ready.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4,
    parameter int              IMEM_AW  = 11
) (
    input  logic clk,
    input  logic rst,
    fetch_prefetch_queue_if.master bus
);

    localparam int              CW         = $clog2(QDEPTH) + 1;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } entry_t;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    entry_t          push_ent;
    entry_t          head_ent;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            issue;
    logic            push;
    logic            pop;

    // A word in flight already owns a queue slot, so count it before issuing another.
    assign issue = (state_q == S_RUN) && !fifo_full
                 && ((fifo_count + CW'(req_valid_q)) < CW'(QDEPTH));
    assign push  = req_valid_q && !bus.redirect_valid;
    assign pop   = bus.out_valid && bus.out_ready;

    assign push_ent = '{instr: bus.imem_rdata, pc: req_pc_q};

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_valid_d = 1'b0;
        req_pc_d    = req_pc_q;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
        endcase
        if (issue) begin
            req_valid_d = 1'b1;
            req_pc_d    = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + PC_STEP;
        end
        if (bus.redirect_valid) begin
            req_valid_d = 1'b0;
            fetch_pc_d  = bus.redirect_pc & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET;
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(entry_t))
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.redirect_valid),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .pop_dat_o  (head_ent),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign bus.imem_rden = issue;
    assign bus.imem_addr = fetch_pc_q[IMEM_AW+1:2];
    assign bus.out_valid = !fifo_empty;
    assign bus.out_instr = head_ent.instr;
    assign bus.out_pc    = head_ent.pc;
    assign bus.out_npc   = head_ent.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: cycle table after reset, scoreboard of expected PCs on every
// handshake, and directed redirect/reset/wrap sequences. ROM model returns 0x1000 + word address.
module tb_fetch_prefetch_queue;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.XLEN(32), .IMEM_AW(11)) bus  ();
    fetch_prefetch_queue_if #(.XLEN(32), .IMEM_AW(11)) bus2 ();

    fetch_prefetch_queue #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .QDEPTH(4), .IMEM_AW(11)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_prefetch_queue #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFFC), .QDEPTH(4), .IMEM_AW(11)
    ) u_wrap (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.master)
    );

    logic [31:0] rom_q  = '0;
    logic [31:0] rom2_q = '0;

    always @(posedge clk) begin
        if (bus.imem_rden)  rom_q  <= 32'h1000 + {21'b0, bus.imem_addr};
        if (bus2.imem_rden) rom2_q <= 32'h1000 + {21'b0, bus2.imem_addr};
    end
    assign bus.imem_rdata  = rom_q;
    assign bus2.imem_rdata = rom2_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Expected PC stream for the main DUT, reloaded whenever stimulus restarts the fetch stream.
    logic [31:0] exp_q [$];

    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        for (int k = 0; k < 128; k++) exp_q.push_back(start + 32'(4 * k));
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h, required no output", bus.out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", bus.out_pc, e);
                chk("sb_instr", bus.out_instr, 32'h1000 + {21'b0, e[12:2]});
                chk("sb_npc", bus.out_npc, e + 32'd4);
            end
        end
    end

    typedef struct {
        logic        rdy;
        logic        v;
        logic        rden;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    task automatic setv(input int i, input logic r, input logic v, input logic d,
                        input logic [31:0] p);
        tbl[i] = '{rdy: r, v: v, rden: d, pc: p};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle-by-cycle view from the first cycle after reset release.
        setv(0, 1'b1, 1'b0, 1'b0, 32'd0);
        setv(1, 1'b1, 1'b0, 1'b1, 32'd0);
        setv(2, 1'b1, 1'b0, 1'b1, 32'd0);
        for (int i = 3; i <= 6; i++) setv(i, 1'b1, 1'b1, 1'b1, 32'(4 * (i - 3)));
        setv(7, 1'b0, 1'b1, 1'b1, 32'd16);
        setv(8, 1'b0, 1'b1, 1'b1, 32'd16);
        for (int i = 9; i <= 16; i++) setv(i, 1'b0, 1'b1, 1'b0, 32'd16);
        setv(17, 1'b1, 1'b1, 1'b0, 32'd16);
        for (int i = 18; i <= 21; i++) setv(i, 1'b1, 1'b1, 1'b1, 32'(20 + 4 * (i - 18)));

        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.out_ready      = 1'b1;

        repeat (3) step();
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_rden", {31'b0, bus.imem_rden}, 32'd0);
        load_stream(32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bus.out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("t%0d_valid", i), {31'b0, bus.out_valid}, {31'b0, tbl[i].v});
            chk($sformatf("t%0d_rden", i), {31'b0, bus.imem_rden}, {31'b0, tbl[i].rden});
            if (tbl[i].v) chk($sformatf("t%0d_pc", i), bus.out_pc, tbl[i].pc);
            step();
        end

        // Three entries queued, then redirect with a pop on the same edge.
        bus.out_ready = 1'b0;
        step();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        load_stream(32'h100);
        chk("redir_valid0", {31'b0, bus.out_valid}, 32'd0);
        chk("redir_rden", {31'b0, bus.imem_rden}, 32'd1);
        chk("redir_addr", {21'b0, bus.imem_addr}, 32'h40);
        step();
        chk("redir_valid1", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("redir_valid2", {31'b0, bus.out_valid}, 32'd1);
        chk("redir_pc", bus.out_pc, 32'h100);

        // Second redirect lands on the edge the 0x200 response returns.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        load_stream(32'h200);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        step();
        bus.redirect_valid = 1'b0;
        load_stream(32'h100);
        chk("kill_valid0", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("kill_valid1", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("kill_valid2", {31'b0, bus.out_valid}, 32'd1);
        chk("kill_pc", bus.out_pc, 32'h100);
        repeat (5) step();

        // Fill the queue, then reset together with a redirect.
        bus.out_ready = 1'b0;
        repeat (8) step();
        chk("full_rden", {31'b0, bus.imem_rden}, 32'd0);
        chk("full_valid", {31'b0, bus.out_valid}, 32'd1);
        rst                = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h500;
        step();
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        load_stream(32'd0);
        bus.out_ready = 1'b1;
        chk("mrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mrst_rden", {31'b0, bus.imem_rden}, 32'd0);
        step();
        chk("mrst_valid1", {31'b0, bus.out_valid}, 32'd0);
        chk("mrst_rden1", {31'b0, bus.imem_rden}, 32'd1);
        chk("mrst_addr", {21'b0, bus.imem_addr}, 32'd0);
        step();
        chk("mrst_valid2", {31'b0, bus.out_valid}, 32'd0);
        step();
        chk("mrst_valid3", {31'b0, bus.out_valid}, 32'd1);
        chk("mrst_pc", bus.out_pc, 32'd0);
        repeat (6) step();

        // PC wrap-around from the top of the address space.
        rst2 = 1'b0;
        for (int k = 0; k < 10 && !bus2.out_valid; k++) step();
        chk("wrap_valid0", {31'b0, bus2.out_valid}, 32'd1);
        chk("wrap_pc0", bus2.out_pc, 32'hFFFF_FFFC);
        chk("wrap_npc0", bus2.out_npc, 32'h0);
        chk("wrap_instr0", bus2.out_instr, 32'h17FF);
        step();
        chk("wrap_valid1", {31'b0, bus2.out_valid}, 32'd1);
        chk("wrap_pc1", bus2.out_pc, 32'h0);
        chk("wrap_npc1", bus2.out_npc, 32'h4);
        chk("wrap_instr1", bus2.out_instr, 32'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
